wave_addr_gen: RTL

- Phase-accumulator (DDS) address generator between the SPI command client and the waveform sample memory.
- Converts 4-bit frequency commands from the SPI client into a per-clock sample address stream for the memory.
- Runs entirely on the system clock, so no derived clock is needed.
- Also provides sample-valid, wrap and run-status indications for downstream DAC output logic.

---
 rtl/wave_addr_gen_if.sv | 30 +++
 rtl/wave_addr_gen.sv | 127 ++++++++++++
 2 files changed

// File: rtl/wave_addr_gen_if.sv
// wave_addr_gen_if: command/sample-address bundle for wave_addr_gen.
//   command        4-bit frequency code from the SPI client (15 = STOP)
//   command_signal command-valid level; a rising edge issues a command
//   addr           sample address to waveform memory
//   addr_valid     high every cycle the accumulator advanced
//   wrap           one-cycle pulse after accumulator overflow
//   running        high when not stopped
//   active_code    code currently driving the accumulator
// master: the address generator.  slave: command source / memory side.
interface wave_addr_gen_if #(
  parameter int unsigned ADDR_W = 9
);
  logic [3:0]        command;
  logic              command_signal;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              wrap;
  logic              running;
  logic [3:0]        active_code;

  modport master (
    input  command, command_signal,
    output addr, addr_valid, wrap, running, active_code
  );

  modport slave (
    output command, command_signal,
    input  addr, addr_valid, wrap, running, active_code
  );
endinterface

// File: rtl/wave_addr_gen.sv
// wave_addr_gen: phase-accumulator (DDS) sample address generator.
// Turns 4-bit frequency commands into a per-clock waveform table address.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  wave_addr_gen_if.master (command, command_signal in;
//        addr, addr_valid, wrap, running, active_code out)
// Tuning word for code k is (k+1) << TW_SHIFT; code 15 stops the generator.
// Optional macro WAVE_ADDR_GEN_WRAP_SYNC_EN: frequency changes are deferred
// until the next accumulator overflow (glitch-free switching). Without it,
// changes take effect on the next cycle with phase continuity.
module wave_addr_gen #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned TW_SHIFT = 14
) (
  input  logic            clk,
  input  logic            rst,
  wave_addr_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STOP,
    ST_PENDING
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  tw;
  logic [ACC_W:0]    sum;
  logic [4:0]        step_mult;
  logic [3:0]        active_code;
  logic              cs_q;
  logic              new_cmd;
  logic              carry;

`ifdef WAVE_ADDR_GEN_WRAP_SYNC_EN
  logic [3:0] pending_code;
  logic       commit;
  logic [3:0] code_eff;
`endif

  assign new_cmd   = bus.command_signal & ~cs_q;
  assign step_mult = {1'b0, active_code} + 5'd1;
  assign tw        = {{(ACC_W-5){1'b0}}, step_mult} << TW_SHIFT;
  assign sum       = {1'b0, acc} + {1'b0, tw};
  assign carry     = sum[ACC_W];

`ifdef WAVE_ADDR_GEN_WRAP_SYNC_EN
  // An overflow commits the pending code first; a command arriving on the
  // same cycle is then judged against that freshly committed code.
  always_comb begin
    commit   = (state == ST_PENDING) && carry;
    code_eff = commit ? pending_code : active_code;
  end
`endif

  assign bus.active_code = active_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q           <= 1'b0;
      state          <= ST_RUN;
      acc            <= '0;
      bus.addr       <= '0;
      bus.addr_valid <= 1'b0;
      bus.wrap       <= 1'b0;
      bus.running    <= 1'b1;
      active_code    <= 4'd0;
`ifdef WAVE_ADDR_GEN_WRAP_SYNC_EN
      pending_code   <= 4'd0;
`endif
    end else begin
      cs_q <= bus.command_signal;
      case (state)
        ST_STOP: begin
          acc            <= '0;
          bus.addr       <= '0;
          bus.addr_valid <= 1'b0;
          bus.wrap       <= 1'b0;
          bus.running    <= 1'b0;
          // Restart from phase zero; the first advance is on the next cycle.
          if (new_cmd && bus.command != 4'hF) begin
            state       <= ST_RUN;
            active_code <= bus.command;
            bus.running <= 1'b1;
          end
        end
        default: begin
          acc            <= sum[ACC_W-1:0];
          bus.addr       <= sum[ACC_W-1 -: ADDR_W];
          bus.addr_valid <= 1'b1;
          bus.wrap       <= carry;
          bus.running    <= 1'b1;
`ifdef WAVE_ADDR_GEN_WRAP_SYNC_EN
          if (commit) begin
            active_code <= pending_code;
            state       <= ST_RUN;
          end
          if (new_cmd && bus.command != 4'hF) begin
            if (bus.command == code_eff) begin
              state <= ST_RUN;
            end else begin
              state        <= ST_PENDING;
              pending_code <= bus.command;
            end
          end
`else
          if (new_cmd && bus.command != 4'hF) begin
            active_code <= bus.command;
          end
`endif
          // STOP overrides the advance and drops any pending switch.
          if (new_cmd && bus.command == 4'hF) begin
            state          <= ST_STOP;
            acc            <= '0;
            bus.addr       <= '0;
            bus.addr_valid <= 1'b0;
            bus.wrap       <= 1'b0;
            bus.running    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
